// File: rtl/j1_io_ctrl.sv
// J1 CPU I/O controller: address decode, LED register, UART RX holding register
// and a small TX FIFO drained into the UART by a four-state strobe FSM.
module j1_io_ctrl #(
  parameter int TX_DEPTH = 4,
  parameter int LED_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [15:0]      io_addr,
  input  logic [15:0]      io_dout,
  output logic [15:0]      io_din,
  output logic             uart_wr,
  output logic [7:0]       uart_tx_data,
  input  logic             uart_busy,
  input  logic             uart_valid,
  input  logic [7:0]       uart_rx_data,
  output logic             uart_rd,
  output logic [LED_W-1:0] leds
);

  localparam int AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TX_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, HOLD, WAIT} txState_t;

  txState_t        r_state, w_nextState;
  logic [7:0]      r_mem [TX_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;
  logic [7:0]      r_txData;
  logic [7:0]      r_rxHold;
  logic            r_rxAvail;
  logic            r_txOvf;
  logic [LED_W-1:0] r_leds;
  logic [15:0]     r_din;

  logic w_selData, w_selStat, w_selLed;
  logic w_wrData, w_rdData, w_rdStat;
  logic w_full, w_empty, w_push, w_pop, w_ovf;
  logic w_txIdle, w_capture;
  logic [15:0] w_rdMux;

  assign w_selData = (io_addr == 16'h1000);
  assign w_selStat = (io_addr == 16'h2000);
  assign w_selLed  = (io_addr == 16'h0004);
  assign w_wrData  = io_wr & w_selData;
  assign w_rdData  = io_rd & w_selData;
  assign w_rdStat  = io_rd & w_selStat;

  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  // A pop in the same cycle frees a slot, so a write on full is still accepted.
  assign w_push   = w_wrData & (~w_full | w_pop);
  assign w_ovf    = w_wrData & w_full & ~w_pop;
  assign w_txIdle = w_empty & (r_state == IDLE);
  assign w_capture = uart_valid & (~r_rxAvail | w_rdData);

  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: if (!w_empty && !uart_busy) w_nextState = SEND;
      SEND: begin
        w_pop       = 1'b1;
        w_nextState = HOLD;
      end
      HOLD: w_nextState = WAIT;
      WAIT: if (!uart_busy) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_rdMux = 16'h0000;
    if (w_selData)      w_rdMux = {8'h00, r_rxHold};
    else if (w_selStat) w_rdMux = {12'h000, w_txIdle, r_txOvf, r_rxAvail, w_full};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_txData <= 8'h00;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE && w_nextState == SEND) r_txData <= r_mem[r_rptr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= io_dout[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxHold  <= 8'h00;
      r_rxAvail <= 1'b0;
      r_txOvf   <= 1'b0;
      r_leds    <= '0;
      r_din     <= 16'h0000;
    end else begin
      if (w_capture) begin
        r_rxHold  <= uart_rx_data;
        r_rxAvail <= 1'b1;
      end else if (w_rdData) begin
        r_rxAvail <= 1'b0;
      end
      // Overflow wins over the status-read clear so a same-cycle drop is not lost.
      if (w_ovf)         r_txOvf <= 1'b1;
      else if (w_rdStat) r_txOvf <= 1'b0;
      if (io_wr && w_selLed) r_leds <= io_dout[LED_W-1:0];
      if (io_rd) r_din <= w_rdMux;
    end
  end

  assign io_din       = r_din;
  assign uart_wr      = (r_state == SEND);
  assign uart_tx_data = r_txData;
  assign uart_rd      = w_capture & ~reset;
  assign leds         = r_leds;

endmodule

// File: tb/tb_j1_io_ctrl.sv
// Self-checking bench for j1_io_ctrl: scoreboards for UART TX bytes and CPU reads,
// plus per-scenario tasks for reset, LEDs, TX ordering/overflow and RX back-pressure.
module tb_j1_io_ctrl;

  logic        clk;
  logic        reset;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_dout;
  logic [15:0] io_din;
  logic        uart_wr;
  logic [7:0]  uart_tx_data;
  logic        uart_busy;
  logic        uart_valid;
  logic [7:0]  uart_rx_data;
  logic        uart_rd;
  logic [4:0]  leds;

  typedef struct {
    string       name;
    logic [15:0] val;
  } rdExp_t;

  int          errors;
  int          checks;
  logic [7:0]  txQ[$];
  rdExp_t      rdQ[$];
  logic        forceBusy;
  logic        autoBusy;
  int          busyCnt;
  logic        rdSeen;
  int          cyc;
  int          lastWr;

  j1_io_ctrl #(.TX_DEPTH(4), .LED_W(5)) dut (
    .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
    .io_dout(io_dout), .io_din(io_din), .uart_wr(uart_wr), .uart_tx_data(uart_tx_data),
    .uart_busy(uart_busy), .uart_valid(uart_valid), .uart_rx_data(uart_rx_data),
    .uart_rd(uart_rd), .leds(leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART busy model: optionally stays busy for 10 cycles after each strobe.
  assign uart_busy = forceBusy | (busyCnt != 0);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (uart_wr && autoBusy) busyCnt <= 10;
    else if (busyCnt != 0)   busyCnt <= busyCnt - 1;
    rdSeen <= io_rd & ~reset;
  end

  // TX scoreboard: every strobe must match the oldest queued byte and respect spacing.
  always @(posedge clk) begin
    if (!reset && uart_wr) begin
      checks++;
      if (uart_busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL tx_while_busy: got busy=%b expected 0", uart_busy);
      end
      if (lastWr >= 0 && (cyc - lastWr) < 4) begin
        errors++;
        $display("[TB] FAIL tx_spacing: got %0d cycles expected >= 4", cyc - lastWr);
      end
      lastWr = cyc;
      if (txQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL tx_unexpected: got byte %h expected no strobe", uart_tx_data);
      end else begin
        logic [7:0] exp;
        exp = txQ.pop_front();
        if (uart_tx_data !== exp) begin
          errors++;
          $display("[TB] FAIL tx_byte: got %h expected %h", uart_tx_data, exp);
        end
      end
    end
  end

  // Read scoreboard: io_din is compared one cycle after each io_rd.
  always @(negedge clk) begin
    if (rdSeen) begin
      rdExp_t e;
      checks++;
      if (rdQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL rd_unexpected: got %h expected no read", io_din);
      end else begin
        e = rdQ.pop_front();
        if (io_din !== e.val) begin
          errors++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, io_din, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ioWrite(input logic [15:0] addr, input logic [15:0] data);
    io_wr = 1'b1; io_addr = addr; io_dout = data;
    tick();
    io_wr = 1'b0; io_addr = 16'h0000; io_dout = 16'h0000;
  endtask

  task automatic ioRead(input logic [15:0] addr, input logic [15:0] exp, input string name);
    rdExp_t e;
    e.name = name; e.val = exp;
    rdQ.push_back(e);
    io_rd = 1'b1; io_addr = addr;
    tick();
    io_rd = 1'b0; io_addr = 16'h0000;
  endtask

  task automatic waitTxDrained(input string name);
    for (int i = 0; i < 400 && txQ.size() != 0; i++) tick();
    checks++;
    if (txQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: got %0d bytes pending expected 0", name, txQ.size());
      txQ.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks += 6;
    if (io_din !== 16'h0000)   begin errors++; $display("[TB] FAIL rst_io_din: got %h expected 0000", io_din); end
    if (uart_wr !== 1'b0)      begin errors++; $display("[TB] FAIL rst_uart_wr: got %b expected 0", uart_wr); end
    if (uart_rd !== 1'b0)      begin errors++; $display("[TB] FAIL rst_uart_rd: got %b expected 0", uart_rd); end
    if (uart_tx_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_tx_data: got %h expected 00", uart_tx_data); end
    if (leds !== 5'b00000)     begin errors++; $display("[TB] FAIL rst_leds: got %b expected 00000", leds); end
    if (dut.r_count !== 3'd0 && io_din === 16'h0000) begin errors++; $display("[TB] FAIL rst_fifo: got %0d expected 0", dut.r_count); end
    reset = 1'b0;
    tick();
    ioRead(16'h2000, 16'h0008, "rst_status");
  endtask

  task automatic test_leds();
    ioWrite(16'h0004, 16'h0015);
    checks++;
    if (leds !== 5'b10101) begin errors++; $display("[TB] FAIL led_write: got %b expected 10101", leds); end
    ioWrite(16'h3000, 16'hFFFF);
    checks++;
    if (leds !== 5'b10101) begin errors++; $display("[TB] FAIL led_unmapped_wr: got %b expected 10101", leds); end
    ioRead(16'h3000, 16'h0000, "unmapped_read");
    ioRead(16'h2000, 16'h0008, "unmapped_wr_status");
    ioRead(16'h0004, 16'h0000, "led_addr_read");
  endtask

  task automatic test_back_to_back();
    autoBusy = 1'b1;
    forceBusy = 1'b0;
    txQ.push_back(8'h41); ioWrite(16'h1000, 16'h0041);
    txQ.push_back(8'h42); ioWrite(16'h1000, 16'h0042);
    txQ.push_back(8'h43); ioWrite(16'h1000, 16'h0043);
    waitTxDrained("b2b_drain");
    repeat (15) tick();
    ioRead(16'h2000, 16'h0008, "b2b_status_idle");
    autoBusy = 1'b0;
  endtask

  task automatic test_overflow();
    forceBusy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) txQ.push_back(8'(8'h10 + i));
      ioWrite(16'h1000, 16'(16'h0010 + i));
    end
    ioRead(16'h2000, 16'h0005, "ovf_status");
    ioRead(16'h2000, 16'h0001, "ovf_cleared");
    forceBusy = 1'b0;
    waitTxDrained("ovf_drain");
    repeat (6) tick();
    ioRead(16'h2000, 16'h0008, "ovf_status_idle");
  endtask

  task automatic test_rx();
    txQ.push_back(8'hA5);
    ioWrite(16'h1000, 16'h00A5);
    waitTxDrained("rx_tx_send");
    forceBusy = 1'b1;
    uart_valid = 1'b1; uart_rx_data = 8'h5A;
    #1;
    checks++;
    if (uart_rd !== 1'b1) begin errors++; $display("[TB] FAIL rx_rd_pulse: got %b expected 1", uart_rd); end
    tick();
    uart_valid = 1'b0; uart_rx_data = 8'h00;
    #1;
    checks++;
    if (uart_rd !== 1'b0) begin errors++; $display("[TB] FAIL rx_rd_single: got %b expected 0", uart_rd); end
    ioRead(16'h2000, 16'h0002, "rx_status_avail");
    ioRead(16'h1000, 16'h005A, "rx_data");
    repeat (3) tick();
    checks++;
    if (io_din !== 16'h005A) begin errors++; $display("[TB] FAIL rx_din_hold: got %h expected 005a", io_din); end
    forceBusy = 1'b0;
    repeat (2) tick();
    ioRead(16'h2000, 16'h0008, "rx_status_after");
    ioRead(16'h1000, 16'h005A, "rx_empty_reread");
  endtask

  task automatic test_rx_backpressure();
    int rdCount;
    uart_valid = 1'b1; uart_rx_data = 8'h11;
    tick();
    uart_rx_data = 8'h33;
    rdCount = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (uart_rd !== 1'b0) rdCount++;
      tick();
    end
    checks++;
    if (rdCount != 0) begin errors++; $display("[TB] FAIL bp_no_rd: got %0d pulses expected 0", rdCount); end
    io_rd = 1'b1; io_addr = 16'h1000;
    #1;
    checks++;
    if (uart_rd !== 1'b1) begin errors++; $display("[TB] FAIL bp_rd_on_read: got %b expected 1", uart_rd); end
    rdQ.push_back('{name: "bp_old_byte", val: 16'h0011});
    tick();
    io_rd = 1'b0; io_addr = 16'h0000;
    uart_valid = 1'b0; uart_rx_data = 8'h00;
    ioRead(16'h2000, 16'h000A, "bp_status_avail");
    ioRead(16'h1000, 16'h0033, "bp_new_byte");
    ioRead(16'h2000, 16'h0008, "bp_status_empty");
  endtask

  task automatic test_reset_mid_send();
    int waited;
    txQ.push_back(8'h61); ioWrite(16'h1000, 16'h0061);
    ioWrite(16'h1000, 16'h0062);
    ioWrite(16'h1000, 16'h0063);
    waited = 0;
    while (uart_wr !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    checks++;
    if (uart_wr !== 1'b1) begin errors++; $display("[TB] FAIL mid_send_reach: got %b expected 1", uart_wr); end
    checks++;
    if (txQ.size() != 0) begin errors++; $display("[TB] FAIL mid_send_first: got %0d pending expected 0", txQ.size()); end
    reset = 1'b1;
    #1;
    checks += 5;
    if (uart_wr !== 1'b0)       begin errors++; $display("[TB] FAIL mid_rst_wr: got %b expected 0", uart_wr); end
    if (uart_tx_data !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_tx_data: got %h expected 00", uart_tx_data); end
    if (io_din !== 16'h0000)    begin errors++; $display("[TB] FAIL mid_rst_io_din: got %h expected 0000", io_din); end
    if (leds !== 5'b00000)      begin errors++; $display("[TB] FAIL mid_rst_leds: got %b expected 00000", leds); end
    if (uart_rd !== 1'b0)       begin errors++; $display("[TB] FAIL mid_rst_rd: got %b expected 0", uart_rd); end
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    ioRead(16'h2000, 16'h0008, "mid_rst_status");
    ioRead(16'h1000, 16'h0000, "mid_rst_rxhold");
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0; io_addr = 16'h0000; io_dout = 16'h0000;
    uart_valid = 1'b0; uart_rx_data = 8'h00;
    forceBusy = 1'b0; autoBusy = 1'b0; busyCnt = 0; rdSeen = 1'b0;
    cyc = 0; lastWr = -1;
    test_reset();
    test_leds();
    test_back_to_back();
    test_overflow();
    test_rx();
    test_rx_backpressure();
    test_reset_mid_send();
    repeat (3) tick();
    checks++;
    if (rdQ.size() != 0) begin errors++; $display("[TB] FAIL rd_pending: got %0d expected 0", rdQ.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
